// File: rtl/bcd_conv_arbiter_if.sv
// ---------------------------------------------------------------------------
// bcd_conv_arbiter_if
//   Bundles every non-clock/reset signal of bcd_conv_arbiter.
//   Parameter: N_REQ (2..8). IDW = $clog2(N_REQ).
//   Groups:
//     request side   : req_valid[N_REQ], req_data[8*N_REQ], req_ack[N_REQ]
//     converter side : conv_start, conv_x7_x0[8], conv_done,
//                      conv_a3_a0/conv_b3_b0/conv_c3_c0[4]
//     response side  : rsp_valid, rsp_ready, rsp_id[IDW],
//                      rsp_a3_a0/rsp_b3_b0/rsp_c3_c0[4], rsp_err
//     status/debug   : busy, dbg_state[2] (FSM encoding), dbg_ptr[IDW]
//   Modports: slave = the arbiter, master = clients + converter + consumer.
//
//   Handshake rules: a response transfers on a rising edge where
//   rsp_valid && rsp_ready. Once rsp_valid is high it stays high and every
//   rsp_* field holds still until that transfer; rsp_valid never depends
//   combinationally on rsp_ready. Requests are level-held: a requester keeps
//   req_valid and its operand until it sees its one-cycle req_ack pulse.
// ---------------------------------------------------------------------------
interface bcd_conv_arbiter_if #(
  parameter int N_REQ = 3
);
  localparam int IDW = $clog2(N_REQ);

  logic [N_REQ-1:0]   req_valid;
  logic [8*N_REQ-1:0] req_data;
  logic [N_REQ-1:0]   req_ack;

  logic               conv_start;
  logic [7:0]         conv_x7_x0;
  logic               conv_done;
  logic [3:0]         conv_a3_a0;
  logic [3:0]         conv_b3_b0;
  logic [3:0]         conv_c3_c0;

  logic               rsp_valid;
  logic               rsp_ready;
  logic [IDW-1:0]     rsp_id;
  logic [3:0]         rsp_a3_a0;
  logic [3:0]         rsp_b3_b0;
  logic [3:0]         rsp_c3_c0;
  logic               rsp_err;

  logic               busy;
  logic [1:0]         dbg_state;
  logic [IDW-1:0]     dbg_ptr;

  modport slave (
    input  req_valid, req_data, conv_done, conv_a3_a0, conv_b3_b0, conv_c3_c0,
           rsp_ready,
    output req_ack, conv_start, conv_x7_x0, rsp_valid, rsp_id, rsp_a3_a0,
           rsp_b3_b0, rsp_c3_c0, rsp_err, busy, dbg_state, dbg_ptr
  );

  modport master (
    output req_valid, req_data, conv_done, conv_a3_a0, conv_b3_b0, conv_c3_c0,
           rsp_ready,
    input  req_ack, conv_start, conv_x7_x0, rsp_valid, rsp_id, rsp_a3_a0,
           rsp_b3_b0, rsp_c3_c0, rsp_err, busy, dbg_state, dbg_ptr
  );
endinterface

// File: rtl/bcd_conv_arbiter.sv
// ---------------------------------------------------------------------------
// bcd_conv_arbiter
//   Shares one 8-bit binary-to-BCD converter among N_REQ requesters.
//   Round-robin grant, latches the winner's operand, pulses conv_start,
//   waits for conv_done and returns the three BCD digits plus the requester
//   id on a valid/ready response port. One conversion in flight at a time.
//
//   Ports:
//     clock  in  system clock, rising edge
//     reset  in  synchronous, active-high
//     bus    bcd_conv_arbiter_if.slave (request, converter, response,
//            busy and debug signals; see the interface file)
//
//   Parameters: N_REQ (2..8), TIMEOUT (WAIT cycle limit, timeout build only)
//
//   Optional feature macro: ARB_TIMEOUT_EN
//     defined   : WAIT aborts after TIMEOUT cycles without conv_done and
//                 returns a response with rsp_err=1 and zero digits.
//     undefined : WAIT is held until conv_done; rsp_err is tied to 0.
//
//   FSM: IDLE -> ISSUE -> WAIT -> RESP -> IDLE. All outputs are registered
//   except busy/debug, which are straight decodes of the state/pointer flops.
// ---------------------------------------------------------------------------
module bcd_conv_arbiter #(
  parameter int N_REQ   = 3,
  parameter int TIMEOUT = 64
) (
  input  logic              clock,
  input  logic              reset,
  bcd_conv_arbiter_if.slave bus
);
  localparam int IDW = $clog2(N_REQ);

  if (N_REQ < 2 || N_REQ > 8 || TIMEOUT < 2) begin : g_param_check
    $error("bcd_conv_arbiter: N_REQ must be 2..8 and TIMEOUT at least 2");
  end

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [IDW-1:0]   ptr_q, ptr_d;
  logic [IDW-1:0]   id_q, id_d;
  logic [7:0]       op_q, op_d;
  logic [N_REQ-1:0] ack_q, ack_d;
  logic             start_q, start_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [3:0]       a_q, a_d;
  logic [3:0]       b_q, b_d;
  logic [3:0]       c_q, c_d;

`ifdef ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT);
  logic [CW-1:0]    tmo_q, tmo_d;
  logic             err_q, err_d;
`endif

  // Round-robin search: first requester at ptr, ptr+1, ... (mod N_REQ).
  logic           grant_found;
  logic [IDW-1:0] grant_id;
  logic [IDW-1:0] cand;
  logic [7:0]     grant_op;

  always_comb begin
    grant_found = 1'b0;
    grant_id    = '0;
    cand        = '0;
    for (int i = 0; i < N_REQ; i++) begin
      cand = IDW'((int'(ptr_q) + i) % N_REQ);
      if (!grant_found && bus.req_valid[cand]) begin
        grant_found = 1'b1;
        grant_id    = cand;
      end
    end
  end

  always_comb begin
    grant_op = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant_id == IDW'(i)) grant_op = bus.req_data[8*i +: 8];
    end
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    id_d        = id_q;
    op_d        = op_q;
    ack_d       = '0;
    start_d     = 1'b0;
    rsp_valid_d = rsp_valid_q;
    a_d         = a_q;
    b_d         = b_q;
    c_d         = c_q;
`ifdef ARB_TIMEOUT_EN
    tmo_d       = tmo_q;
    err_d       = err_q;
`endif

    unique case (state_q)
      S_IDLE: begin
        // ack and start are raised together so both appear in the ISSUE cycle.
        if (grant_found) begin
          state_d         = S_ISSUE;
          id_d            = grant_id;
          op_d            = grant_op;
          ack_d[grant_id] = 1'b1;
          start_d         = 1'b1;
        end
      end

      S_ISSUE: begin
        state_d = S_WAIT;
`ifdef ARB_TIMEOUT_EN
        tmo_d   = '0;
`endif
      end

      S_WAIT: begin
        // A done arriving on the expiry edge still yields a normal response.
        if (bus.conv_done) begin
          state_d     = S_RESP;
          rsp_valid_d = 1'b1;
          a_d         = bus.conv_a3_a0;
          b_d         = bus.conv_b3_b0;
          c_d         = bus.conv_c3_c0;
`ifdef ARB_TIMEOUT_EN
          err_d       = 1'b0;
        end else if (tmo_q == CW'(TIMEOUT - 1)) begin
          state_d     = S_RESP;
          rsp_valid_d = 1'b1;
          a_d         = '0;
          b_d         = '0;
          c_d         = '0;
          err_d       = 1'b1;
        end else begin
          tmo_d       = tmo_q + 1'b1;
`endif
        end
      end

      S_RESP: begin
        if (rsp_valid_q && bus.rsp_ready) begin
          state_d     = S_IDLE;
          rsp_valid_d = 1'b0;
          // Next search starts just after the requester that was served.
          if (id_q == IDW'(N_REQ - 1)) ptr_d = '0;
          else                         ptr_d = id_q + 1'b1;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= S_IDLE;
      ptr_q       <= '0;
      id_q        <= '0;
      op_q        <= '0;
      ack_q       <= '0;
      start_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      c_q         <= '0;
`ifdef ARB_TIMEOUT_EN
      tmo_q       <= '0;
      err_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      id_q        <= id_d;
      op_q        <= op_d;
      ack_q       <= ack_d;
      start_q     <= start_d;
      rsp_valid_q <= rsp_valid_d;
      a_q         <= a_d;
      b_q         <= b_d;
      c_q         <= c_d;
`ifdef ARB_TIMEOUT_EN
      tmo_q       <= tmo_d;
      err_q       <= err_d;
`endif
    end
  end

  assign bus.req_ack    = ack_q;
  assign bus.conv_start = start_q;
  assign bus.conv_x7_x0 = op_q;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_id     = id_q;
  assign bus.rsp_a3_a0  = a_q;
  assign bus.rsp_b3_b0  = b_q;
  assign bus.rsp_c3_c0  = c_q;
`ifdef ARB_TIMEOUT_EN
  assign bus.rsp_err    = err_q;
`else
  assign bus.rsp_err    = 1'b0;
`endif
  assign bus.busy       = (state_q != S_IDLE);
  assign bus.dbg_state  = state_q;
  assign bus.dbg_ptr    = ptr_q;

endmodule

// File: tb/tb_bcd_conv_arbiter.sv
// ---------------------------------------------------------------------------
// tb_bcd_conv_arbiter
//   Directed bench for bcd_conv_arbiter (N_REQ=3, TIMEOUT=64) with a
//   converter model of fixed latency L=8 whose digits come from the operand
//   captured on conv_start. Expected responses are queued when a request is
//   driven and popped when the DUT presents rsp_valid.
// ---------------------------------------------------------------------------
module tb_bcd_conv_arbiter;
  localparam int N_REQ   = 3;
  localparam int TIMEOUT = 64;
  localparam int L       = 8;
  localparam int W       = 16;

  // ---------------- clock / reset ----------------
  logic clock;
  logic reset;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  bcd_conv_arbiter_if #(.N_REQ(N_REQ)) bus ();

  bcd_conv_arbiter #(.N_REQ(N_REQ), .TIMEOUT(TIMEOUT)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  // ---------------- converter model ----------------
  int         m_cnt = 0;
  logic [3:0] m_a = '0, m_b = '0, m_c = '0;
  logic       conv_en;

  always @(posedge clock) begin
    if (bus.conv_start) begin
      m_cnt <= L;
      m_a   <= 4'(int'(bus.conv_x7_x0) / 100);
      m_b   <= 4'((int'(bus.conv_x7_x0) / 10) % 10);
      m_c   <= 4'(int'(bus.conv_x7_x0) % 10);
    end else if (m_cnt != 0) begin
      m_cnt <= m_cnt - 1;
    end
  end

  assign bus.conv_done  = conv_en && (m_cnt == 1);
  assign bus.conv_a3_a0 = m_a;
  assign bus.conv_b3_b0 = m_b;
  assign bus.conv_c3_c0 = m_c;

  // ---------------- monitors ----------------
  int cyc = 0;
  int ack_cnt = 0, start_cnt = 0, rsp_cnt = 0, wait_cnt = 0;

  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    if (bus.req_ack != '0)        ack_cnt   <= ack_cnt + 1;
    if (bus.conv_start === 1'b1)  start_cnt <= start_cnt + 1;
    if (bus.rsp_valid === 1'b1)   rsp_cnt   <= rsp_cnt + 1;
    if (bus.dbg_state === 2'd2)   wait_cnt  <= wait_cnt + 1;
  end

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] pack(input logic err, input int id,
                                        input int a, input int b, input int c);
    return {err, 3'(id), 4'(a), 4'(b), 4'(c)};
  endfunction

  function automatic logic [W-1:0] exp_of(input int id, input int op);
    return pack(1'b0, id, op / 100, (op / 10) % 10, op % 10);
  endfunction

  function automatic logic [W-1:0] obs_rsp();
    return {bus.rsp_err, 3'(bus.rsp_id), bus.rsp_a3_a0, bus.rsp_b3_b0, bus.rsp_c3_c0};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic pulse_reset();
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic wait_ack(input int id);
    int n;
    logic [N_REQ-1:0] oh;
    oh = '0;
    oh[id] = 1'b1;
    n = 0;
    while (bus.req_ack == '0 && n < 8) begin
      @(negedge clock);
      n++;
    end
    chk("ack_onehot", 32'(bus.req_ack), 32'(oh));
  endtask

  // One full transaction: ack, response, optional backpressure, handshake.
  task automatic do_txn(input int id, input int op, input bit drop,
                        input int hold, input int exp_lat);
    int n, t_ack, st0;
    logic [W-1:0] exp;
    st0 = start_cnt;
    wait_ack(id);
    t_ack = cyc;
    if (drop) bus.req_valid[id] = 1'b0;
    @(negedge clock);
    chk("ack_pulse", 32'(bus.req_ack), 32'd0);
    n = 0;
    while (bus.rsp_valid !== 1'b1 && n < 200) begin
      @(negedge clock);
      n++;
    end
    chk("rsp_valid", 32'(bus.rsp_valid), 32'd1);
    chk("latency", 32'(cyc - t_ack), 32'(exp_lat));
    chk("conv_x", 32'(bus.conv_x7_x0), 32'(op));
    chk("start_once", 32'(start_cnt - st0), 32'd1);
    chk("q_nonempty", 32'(exp_q.size() > 0), 32'd1);
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
    chk("rsp_fields", 32'(obs_rsp()), 32'(exp));
    for (int i = 0; i < hold; i++) begin
      @(negedge clock);
      chk("hold_fields", 32'(obs_rsp()), 32'(exp));
      chk("hold_valid", 32'(bus.rsp_valid), 32'd1);
      chk("hold_ack", 32'(bus.req_ack), 32'd0);
      chk("hold_start", 32'(start_cnt - st0), 32'd1);
    end
    bus.rsp_ready = 1'b1;
    @(negedge clock);
    bus.rsp_ready = 1'b0;
    chk("rsp_drop", 32'(bus.rsp_valid), 32'd0);
    chk("busy_after", 32'(bus.busy), 32'd0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int a0, r0, w0, b1;
    reset         = 1'b1;
    conv_en       = 1'b1;
    bus.rsp_ready = 1'b0;
    bus.req_data  = '0;

    // 1: reset held 2 cycles with all requests pending
    bus.req_valid = 3'b111;
    repeat (2) @(negedge clock);
    chk("rst_ack",       32'(bus.req_ack),    32'd0);
    chk("rst_start",     32'(bus.conv_start), 32'd0);
    chk("rst_conv_x",    32'(bus.conv_x7_x0), 32'd0);
    chk("rst_rsp_valid", 32'(bus.rsp_valid),  32'd0);
    chk("rst_rsp",       32'(obs_rsp()),      32'd0);
    chk("rst_busy",      32'(bus.busy),       32'd0);
    chk("rst_state",     32'(bus.dbg_state),  32'd0);
    chk("rst_ptr",       32'(bus.dbg_ptr),    32'd0);
    chk("rst_ack_cnt",   32'(ack_cnt),        32'd0);
    reset         = 1'b0;
    bus.req_valid = '0;

    // 2: single request from 0, operand 0x69 = 105
    bus.req_data  = {8'd0, 8'd0, 8'h69};
    bus.req_valid = 3'b001;
    exp_q.push_back(exp_of(0, 8'h69));
    do_txn(0, 8'h69, 1'b1, 0, L + 1);
    chk("t2_ptr", 32'(bus.dbg_ptr), 32'd1);

    // 3: all three pending and held -> order 0,1,2,0
    pulse_reset();
    bus.req_data  = {8'd99, 8'd0, 8'd255};
    bus.req_valid = 3'b111;
    exp_q.push_back(exp_of(0, 255));
    exp_q.push_back(exp_of(1, 0));
    exp_q.push_back(exp_of(2, 99));
    exp_q.push_back(exp_of(0, 255));
    a0 = ack_cnt;
    do_txn(0, 255, 1'b0, 0, L + 1);
    do_txn(1, 0,   1'b0, 0, L + 1);
    do_txn(2, 99,  1'b0, 0, L + 1);
    do_txn(0, 255, 1'b0, 0, L + 1);
    bus.req_valid = '0;
    @(negedge clock);
    chk("t3_acks", 32'(ack_cnt - a0), 32'd4);
    chk("t3_ptr",  32'(bus.dbg_ptr),  32'd1);

    // 4: backpressure for 5 cycles, requester 2, operand 137
    bus.req_data  = {8'd137, 8'd0, 8'd0};
    bus.req_valid = 3'b100;
    exp_q.push_back(exp_of(2, 137));
    do_txn(2, 137, 1'b1, 5, L + 1);
    chk("t4_ptr", 32'(bus.dbg_ptr), 32'd0);

    // 5: reset while waiting; the late conv_done must be ignored
    bus.req_data  = {8'd0, 8'd42, 8'd0};
    bus.req_valid = 3'b010;
    wait_ack(1);
    bus.req_valid = '0;
    repeat (2) @(negedge clock);
    chk("t5_in_wait", 32'(bus.dbg_state), 32'd2);
    pulse_reset();
    chk("t5_busy",  32'(bus.busy),      32'd0);
    chk("t5_state", 32'(bus.dbg_state), 32'd0);
    chk("t5_ptr",   32'(bus.dbg_ptr),   32'd0);
    r0 = rsp_cnt;
    a0 = ack_cnt;
    bus.rsp_ready = 1'b1;
    repeat (15) @(negedge clock);
    bus.rsp_ready = 1'b0;
    chk("t5_no_rsp", 32'(rsp_cnt - r0), 32'd0);
    chk("t5_no_ack", 32'(ack_cnt - a0), 32'd0);
    chk("t5_idle",   32'(bus.busy),     32'd0);

    // 6: converter never completes
    conv_en       = 1'b0;
    bus.req_data  = {8'd0, 8'd0, 8'd5};
    bus.req_valid = 3'b001;
`ifdef ARB_TIMEOUT_EN
    w0 = wait_cnt;
    exp_q.push_back(pack(1'b1, 0, 0, 0, 0));
    do_txn(0, 5, 1'b1, 0, TIMEOUT + 1);
    chk("t6_wait_cycles", 32'(wait_cnt - w0), 32'(TIMEOUT));
`else
    wait_ack(0);
    bus.req_valid = '0;
    @(negedge clock);
    w0 = wait_cnt;
    r0 = rsp_cnt;
    b1 = 0;
    repeat (200) begin
      @(negedge clock);
      if (bus.busy === 1'b1) b1++;
    end
    chk("t6_busy_cycles", 32'(b1), 32'd200);
    chk("t6_wait_cycles", 32'(wait_cnt - w0), 32'd200);
    chk("t6_no_rsp",      32'(rsp_cnt - r0),  32'd0);
    chk("t6_err_tied",    32'(bus.rsp_err),   32'd0);
    pulse_reset();
`endif
    conv_en = 1'b1;
    chk("q_empty", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
